rs232_tx_packet: RTL and testbench
==================================

// Module: rs232_tx_packet
// PURPOSE
//  Downstream stage of the RS232 packet receiver. On a read request (tx_start
//  pulse) it latches the 32-bit RAM word and its address, frames an 8-byte
//  response packet and shifts it out as 8N1 UART, LSB first, on the tx line.
//  The packet layout matches the receive packet:
//  02 | {0,addr} | d[7:0] | d[15:8] | d[23:16] | d[31:24] | 00 | 03
// PARAMETERS
//  CLKS_PER_BIT  2494  clk cycles per serial bit; equals the receiver's 2x1247 sample period
//  GAP_BITS      2     idle (high) bit times after every byte, so the receiver re-arms
//  PKT_BYTES     8     bytes per packet; fixed by the protocol, not for override
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous, active-high reset
//  tx_start  in   1   1-cycle request pulse; ram_out and addr are valid in the same cycle
//  ram_out   in   32  RAM read word to return
//  addr      in   7   RAM address echoed in byte 1
//  tx        out  1   serial line; idle high
//  busy      out  1   high from the cycle after an accepted tx_start until the last gap ends
//  done      out  1   1-cycle pulse in the cycle after busy falls
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high.
//  - Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset mid-packet
//    aborts in the next cycle and drives tx=1 immediately. A truncated byte is not completed.
//  - Accept: tx_start=1 in IDLE latches {addr,ram_out} into an 8x8 byte buffer.
//    busy=1 and tx=0 (start bit) from cycle N+1. tx_start while busy is ignored; no queueing.
//  - FSM: IDLE -> START (1 bit) -> DATA (8 bits, LSB first) -> STOP (1 bit, tx=1)
//    -> GAP (GAP_BITS bits, tx=1).
//    GAP exit: if byte_idx < 7, byte_idx++ and go to START. If byte_idx == 7, go to IDLE,
//    busy=0, done=1 for one cycle.
//  - Bit timer counts 0..CLKS_PER_BIT-1. The state/bit advances when timer == CLKS_PER_BIT-1,
//    then the timer wraps to 0. bit_idx is 3 bits and wraps 7->0 on leaving DATA.
//    The GAP counter is sized to GAP_BITS. GAP_BITS=0 skips GAP.
//  - tx is registered, so there are no glitches. Each bit lasts exactly CLKS_PER_BIT cycles.
//  - Packet duration: PKT_BYTES*(10+GAP_BITS)*CLKS_PER_BIT cycles of busy.
//    With the defaults this is 8*12*2494 = 239424 cycles.
//  - tx_start in the same cycle as done: done is generated in IDLE, so the request is
//    accepted and a new packet starts at the next cycle.
//  - tx_start coincident with rst: rst wins; the request is dropped.
//  - Byte 6 is reserved and transmitted as 8'h00. Byte 1 bit7 is 0 (read response).
// STRUCTURE
//  - Shared package rs232_pkg: STX=8'h02, ETX=8'h03, PKT_BYTES=8, and the state
//    encoding typedef/localparams (IDLE, START, DATA, STOP, GAP), shared with the
//    receiver's framing constants.
//  - One sub-module, uart_tx_byte: bit timer plus START/DATA/STOP/GAP serializer with a
//    load/ready handshake. The top level holds the byte buffer, byte_idx, busy and done.
// TESTING
//  1. Reset idle: rst held 5 cycles, then released -> tx=1, busy=0, done=0 for 10000 cycles.
//  2. Single packet: addr=7'h15, ram_out=32'hDEADBEEF, one tx_start pulse.
//     -> The bench UART decoder sees bytes 02 15 EF BE AD DE 00 03.
//     -> tx falls at N+1; busy lasts 239424 cycles; done pulses once.
//  3. Bit timing: measure every tx edge.
//     -> Each edge is at a multiple of 2494 cycles from the start-bit edge.
//     -> The start-bit low before byte 1 comes exactly 3*2494 cycles after byte 0's stop
//        bit begins.
//  4. Busy ignore: a second tx_start (ram_out=32'h12345678) mid-byte 3.
//     -> The packet still carries DEADBEEF. No second packet. done pulses once.
//  5. Reset mid-operation: rst pulse during the DATA bits of byte 4.
//     -> tx=1 and busy=0 the next cycle. A following tx_start sends a full correct packet.
//  6. Back-to-back: tx_start in the done cycle with ram_out=32'h00000001, addr=7'h7F.
//     -> The second packet 02 7F 01 00 00 00 00 03 starts 1 cycle later.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: framing constants, serializer state encoding and packet builder shared by the RS232 blocks.
package rs232_pkg;
   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] ETX = 8'h03;
   localparam int PKT_BYTES = 8;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
   // Byte i of the packet sits at bits [8i+7:8i]; byte 6 is reserved, byte 1 bit7 marks a read response.
   function automatic logic [8*PKT_BYTES-1:0] build_pkt(input logic [6:0] addr, input logic [31:0] data);
      return {ETX, 8'h00, data, 1'b0, addr, STX};
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with trailing idle gap; ready is high in IDLE and in the last gap cycle.
module uart_tx_byte import rs232_pkg::*; #(
   parameter int CLKS_PER_BIT = 2494,
   parameter int GAP_BITS     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);
   localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
   state_t state, state_d;
   logic [TW-1:0] timer;
   logic [GW-1:0] gap_cnt;
   logic [2:0] bit_idx, bit_d;
   logic [7:0] shreg;
   logic tick, byte_end, tx_d;
   assign tick = state != IDLE && timer == T_LAST;
   // Loading in the final gap cycle chains bytes with no idle cycle between them.
   assign byte_end = tick && ((state == GAP && gap_cnt == G_LAST) || (state == STOP && GAP_BITS == 0));
   assign ready = state == IDLE || byte_end;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         gap_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_d;
         timer   <= (state == IDLE || tick) ? '0 : timer + 1'b1;
         gap_cnt <= (state == GAP && tick) ? (gap_cnt == G_LAST ? '0 : gap_cnt + 1'b1) : gap_cnt;
         bit_idx <= bit_d;
         if (load && ready) shreg <= data;
         tx      <= tx_d;
      end
   end
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = load ? START : IDLE;
         START:   if (tick) state_d = DATA;
         DATA:    if (tick && bit_idx == 3'd7) state_d = STOP;
         STOP:    if (tick) state_d = GAP_BITS == 0 ? (load ? START : IDLE) : GAP;
         GAP:     if (byte_end) state_d = load ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bit_d = (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
      tx_d  = state_d == START ? 1'b0 : state_d == DATA ? shreg[bit_d] : 1'b1;
   end
endmodule

// File: rtl/rs232_tx_packet.sv
// rs232_tx_packet: latches a RAM read response and sends it as an 8-byte framed 8N1 packet.
module rs232_tx_packet import rs232_pkg::*; #(
   parameter int CLKS_PER_BIT = 2494,
   parameter int GAP_BITS     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [31:0] ram_out,
   input  logic [6:0]  addr,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   logic [8*PKT_BYTES-1:0] pkt;
   logic [2:0] byte_idx, idx_nxt;
   logic [7:0] byte_d;
   logic ready, load, last;
   assign idx_nxt = byte_idx + 3'd1;
   assign last    = byte_idx == 3'(PKT_BYTES - 1);
   // Byte 0 is STX, fed straight from the constant so the start bit goes out the cycle after accept.
   assign load    = busy ? ready && !last : tx_start;
   assign byte_d  = busy ? pkt[{idx_nxt, 3'b000} +: 8] : STX;
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt      <= '0;
         byte_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= busy && ready && last;
         if (!busy && tx_start) begin
            pkt      <= build_pkt(addr, ram_out);
            byte_idx <= '0;
            busy     <= 1'b1;
         end else if (busy && ready) begin
            if (last) busy <= 1'b0;
            else byte_idx <= idx_nxt;
         end
      end
   end
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT), .GAP_BITS(GAP_BITS)) u_byte (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .data  (byte_d),
      .tx    (tx),
      .ready (ready)
   );
endmodule

// File: tb/tb_rs232_tx_packet.sv
// tb_rs232_tx_packet: table-driven packet checks with a cycle-exact UART decoder plus reset/busy corner sequences.
module tb_rs232_tx_packet;
   localparam int CB  = 8;
   localparam int GAP = 2;
   localparam int PKT_CYC = 8 * (10 + GAP) * CB;
   typedef struct {
      logic [6:0]  a;
      logic [31:0] d;
      logic [63:0] exp;
      bit          b2b;
      int          inj;
   } vec_t;
   logic clk = 0, rst = 1, tx_start = 0;
   logic [31:0] ram_out = '0;
   logic [6:0]  addr = '0;
   logic tx, busy, done;
   int cyc = 0, done_cnt = 0, pkts = 0, total = 0, bad = 0;
   vec_t vecs [5];
   rs232_tx_packet #(.CLKS_PER_BIT(CB), .GAP_BITS(GAP)) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .ram_out(ram_out), .addr(addr),
      .tx(tx), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      done_cnt <= done_cnt + int'(done);
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic abort(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event", name);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask
   task automatic idle_check(input int n);
      logic ok;
      ok = 1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 0;
      end
      check("idle_line", ok, 1);
   endtask
   task automatic send(input vec_t v);
      int t_busy, t_prev, n;
      logic [7:0] by;
      logic bv, ok;
      tx_start = 1;
      addr = v.a;
      ram_out = v.d;
      @(negedge clk);
      tx_start = 0;
      check("start_bit_n1", tx, 0);
      check("busy_rise", busy, 1);
      check("done_low", done, 0);
      t_busy = cyc;
      t_prev = cyc;
      for (int b = 0; b < 8; b++) begin
         if (b > 0) begin
            n = 0;
            while (tx !== 1'b0 && n < 4 * CB) begin
               @(negedge clk);
               n++;
            end
            if (tx !== 1'b0) abort("start_edge");
            check("byte_spacing", 64'(cyc - t_prev), 64'((10 + GAP) * CB));
            t_prev = cyc;
         end
         ok = 1;
         by = '0;
         bv = 1'b0;
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < CB; j++) begin
               if (b == v.inj && k == 3) begin
                  tx_start = (j == 0);
                  ram_out = 32'h12345678;
               end
               if (j == 0) bv = tx;
               else if (tx !== bv) ok = 0;
               @(negedge clk);
            end
            if (k == 0) check("start_bit", bv, 0);
            else if (k == 9) check("stop_bit", bv, 1);
            else by[k-1] = bv;
         end
         check("bit_stable", ok, 1);
         check($sformatf("byte%0d", b), by, v.exp[8*b +: 8]);
      end
      n = 0;
      while (busy === 1'b1 && n < 4 * CB) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) abort("busy_fall");
      check("busy_len", 64'(cyc - t_busy), 64'(PKT_CYC));
      check("done_pulse", done, 1);
      pkts++;
   endtask
   initial begin
      vecs[0] = '{a: 7'h15, d: 32'hDEADBEEF, exp: 64'h0300_DEAD_BEEF_1502, b2b: 0, inj: -1};
      vecs[1] = '{a: 7'h7F, d: 32'h00000001, exp: 64'h0300_0000_0001_7F02, b2b: 1, inj: -1};
      vecs[2] = '{a: 7'h15, d: 32'hDEADBEEF, exp: 64'h0300_DEAD_BEEF_1502, b2b: 0, inj: 3};
      vecs[3] = '{a: 7'h00, d: 32'hFFFFFFFF, exp: 64'h0300_FFFF_FFFF_0002, b2b: 0, inj: -1};
      vecs[4] = '{a: 7'h2A, d: 32'hA5C30F81, exp: 64'h0300_A5C3_0F81_2A02, b2b: 0, inj: -1};
      repeat (5) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst = 0;
      idle_check(10000);
      for (int i = 0; i < 5; i++) begin
         if (!vecs[i].b2b) begin
            idle_check(20 * CB);
            check("done_count", 64'(done_cnt), 64'(pkts));
         end
         send(vecs[i]);
      end
      idle_check(20 * CB);
      check("done_count", 64'(done_cnt), 64'(pkts));
      tx_start = 1;
      addr = 7'h15;
      ram_out = 32'hDEADBEEF;
      @(negedge clk);
      tx_start = 0;
      repeat ((4 * (10 + GAP) + 1 + 3) * CB) @(negedge clk);
      check("busy_pre_rst", busy, 1);
      rst = 1;
      tx_start = 1;
      @(negedge clk);
      rst = 0;
      tx_start = 0;
      check("rst_abort_tx", tx, 1);
      check("rst_abort_busy", busy, 0);
      idle_check(20 * CB);
      check("done_count_rst", 64'(done_cnt), 64'(pkts));
      send(vecs[0]);
      idle_check(4 * CB);
      check("done_count_end", 64'(done_cnt), 64'(pkts));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
